// File: rtl/drp_sample_reader.sv
// drp_sample_reader
//   Reads two ADC channels over a single DRP read port once per sample period
//   and publishes them as one pair. Channel A is the signal and channel B is
//   the noise reference. The module also generates the sample strobe that
//   paces the downstream LMS filter. It detects response timeouts and overruns
//   of the sample period.
//
// Ports
//   clk           system clock
//   rst_n         async active-low reset (deassertion is synchronous to clk)
//   en            enables periodic sampling
//   drp_addr      DRP address; 0 whenever drp_rd_en is low
//   drp_rd_en     DRP read request, single-cycle pulse
//   drp_rd_data   DRP read data, qualified by drp_data_rdy
//   drp_data_rdy  DRP response strobe
//   sample_a      last completed channel A sample
//   sample_b      last completed channel B sample
//   sample_valid  1-cycle pulse marking a new sample_a/sample_b pair
//   timeout_err   sticky, set when a read receives no response in time
//   overrun_err   sticky, set when a tick arrives while a pair is in flight
//   err_count     count of timeouts plus overruns, saturating at 8'hFF
//
// state  | meaning
// IDLE   | waiting for the sample tick
// REQ_A  | drp_rd_en high with ADDR_A
// WAIT_A | waiting for the channel A response
// REQ_B  | drp_rd_en high with ADDR_B
// WAIT_B | waiting for the channel B response
// DONE   | sample_valid high; the new pair is on sample_a/sample_b
module drp_sample_reader #(
  parameter logic [6:0] ADDR_A        = 7'h10,
  parameter logic [6:0] ADDR_B        = 7'h11,
  parameter int         SAMPLE_PERIOD = 16,
  parameter int         TIMEOUT       = 32,
  parameter int         ADC_WIDTH     = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [6:0]           drp_addr,
  output logic                 drp_rd_en,
  input  logic [15:0]          drp_rd_data,
  input  logic                 drp_data_rdy,
  output logic [ADC_WIDTH-1:0] sample_a,
  output logic [ADC_WIDTH-1:0] sample_b,
  output logic                 sample_valid,
  output logic                 timeout_err,
  output logic                 overrun_err,
  output logic [7:0]           err_count
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_A  = 3'd1,
    WAIT_A = 3'd2,
    REQ_B  = 3'd3,
    WAIT_B = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]        per_cnt;
  logic [TW-1:0]        wait_cnt;
  logic [ADC_WIDTH-1:0] hold_a;
  logic                 tick;
  logic                 overrun;
  logic                 to_hit;
  logic                 cap_a;
  logic                 cap_b;
  logic                 rd_en_nxt;
  logic [6:0]           addr_nxt;
  logic                 valid_nxt;
  logic [1:0]           err_inc;
  logic [8:0]           err_sum;

  // Bits of drp_rd_data above the ADC width are intentionally discarded.
  if (ADC_WIDTH < 16) begin : g_unused
    logic unused_rd_bits;
    assign unused_rd_bits = ^drp_rd_data[15:ADC_WIDTH];
  end

  // The period counter is held at 0 while disabled, so a re-enable always
  // waits one full period before the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (!en || per_cnt == PER_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  assign tick    = en && (per_cnt == PER_LAST);
  assign overrun = tick && (state != IDLE);

  // The wait timer is loaded during the request cycle, so it reads TIMEOUT-1
  // in the first WAIT cycle and reaches 0 in the TIMEOUT-th cycle. A response
  // in that last cycle still wins over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == REQ_A || state == REQ_B) begin
      wait_cnt <= WAIT_LOAD;
    end else if (wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE:   if (tick) state_nxt = REQ_A;
      REQ_A:  state_nxt = WAIT_A;
      WAIT_A: begin
        if (drp_data_rdy) begin
          cap_a     = 1'b1;
          state_nxt = REQ_B;
        end else if (wait_cnt == '0) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      REQ_B:  state_nxt = WAIT_B;
      WAIT_B: begin
        if (drp_data_rdy) begin
          cap_b     = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == '0) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state, so they line up with
  // the state they describe.
  always_comb begin
    rd_en_nxt = 1'b0;
    addr_nxt  = 7'd0;
    valid_nxt = 1'b0;
    if (state_nxt == REQ_A) begin
      rd_en_nxt = 1'b1;
      addr_nxt  = ADDR_A;
    end else if (state_nxt == REQ_B) begin
      rd_en_nxt = 1'b1;
      addr_nxt  = ADDR_B;
    end
    if (state_nxt == DONE) valid_nxt = 1'b1;
  end

  assign err_inc = {1'b0, overrun} + {1'b0, to_hit};
  assign err_sum = {1'b0, err_count} + {7'd0, err_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drp_rd_en    <= 1'b0;
      drp_addr     <= 7'd0;
      sample_valid <= 1'b0;
      hold_a       <= '0;
      sample_a     <= '0;
      sample_b     <= '0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      drp_rd_en    <= rd_en_nxt;
      drp_addr     <= addr_nxt;
      sample_valid <= valid_nxt;
      if (cap_a) hold_a <= drp_rd_data[ADC_WIDTH-1:0];
      // Publish A and B together on the edge entering DONE. This keeps a
      // lone A from ever being visible and aligns the pair with sample_valid.
      if (cap_b) begin
        sample_a <= hold_a;
        sample_b <= drp_rd_data[ADC_WIDTH-1:0];
      end
      if (to_hit)  timeout_err <= 1'b1;
      if (overrun) overrun_err <= 1'b1;
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_drp_sample_reader.sv
module tb_drp_sample_reader;

  localparam int SP = 16;
  localparam int TO = 32;
  localparam logic [6:0] ADDR_A = 7'h10;
  localparam logic [6:0] ADDR_B = 7'h11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [6:0]  drp_addr;
  logic        drp_rd_en;
  logic [15:0] drp_rd_data = 16'd0;
  logic        drp_data_rdy = 1'b0;
  logic [11:0] sample_a;
  logic [11:0] sample_b;
  logic        sample_valid;
  logic        timeout_err;
  logic        overrun_err;
  logic [7:0]  err_count;

  drp_sample_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .drp_addr     (drp_addr),
    .drp_rd_en    (drp_rd_en),
    .drp_rd_data  (drp_rd_data),
    .drp_data_rdy (drp_data_rdy),
    .sample_a     (sample_a),
    .sample_b     (sample_b),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err),
    .overrun_err  (overrun_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Responder and scoreboard state
  int          cyc = 0;
  int          lat_a = 1, lat_b = 1;
  bit          ign_a = 0, ign_b = 0;
  bit          fixed = 0;
  logic [15:0] fix_a = 16'h0, fix_b = 16'h0;
  bit          pend = 0;
  int          due = 0;
  logic [15:0] pdata = 16'h0;
  bit          pis_b = 0;
  int          b_cyc = -10;
  bit          next_b = 0;
  logic [11:0] last_a = 12'h0;
  logic [23:0] exp_q[$];
  logic [11:0] pub_a = 12'h0, pub_b = 12'h0;
  int          nvalid = 0;
  int          vcyc[$];
  logic        prev_rd_en = 1'b0;
  logic [7:0]  prev_err = 8'h0;
  int          spur = 0;
  int          r0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    pend = 0;
    exp_q.delete();
    next_b = 0;
    pub_a = 12'h0;
    pub_b = 12'h0;
    prev_rd_en = 1'b0;
    prev_err = 8'h0;
    spur = 0;
  endtask

  // One clock: sample DUT at the falling edge, check, then drive the DRP side.
  task automatic step();
    bit          is_b;
    int          lat;
    bit          ign;
    logic [15:0] d;
    logic [23:0] p;
    @(negedge clk);
    cyc++;
    if (!drp_rd_en) chk("addr_zero_when_idle", drp_addr, 0);
    else            chk("rd_en_single_cycle", prev_rd_en, 0);
    if (sample_valid) begin
      nvalid++;
      vcyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("valid_unexpected", 1, 0);
      end else begin
        p = exp_q.pop_front();
        chk("pair_a", sample_a, p[23:12]);
        chk("pair_b", sample_b, p[11:0]);
        chk("valid_latency", cyc, b_cyc + 1);
        pub_a = p[23:12];
        pub_b = p[11:0];
      end
    end else begin
      chk("hold_a", sample_a, pub_a);
      chk("hold_b", sample_b, pub_b);
    end
    chk("err_no_wrap", err_count >= prev_err, 1);
    prev_err   = err_count;
    prev_rd_en = drp_rd_en;

    drp_data_rdy = 1'b0;
    drp_rd_data  = 16'($urandom);
    if (!rst_n) pend = 0;
    if (pend && cyc == due) begin
      drp_data_rdy = 1'b1;
      drp_rd_data  = pdata;
      pend = 0;
      if (pis_b) b_cyc = cyc;
    end else if (spur > 0) begin
      drp_data_rdy = 1'b1;
      spur--;
    end
    if (drp_rd_en && rst_n) begin
      is_b = next_b;
      chk("req_addr", drp_addr, is_b ? ADDR_B : ADDR_A);
      lat = is_b ? lat_b : lat_a;
      ign = is_b ? ign_b : ign_a;
      d = fixed ? (is_b ? fix_b : fix_a) : 16'($urandom);
      if (!ign) begin
        pend  = 1;
        due   = cyc + lat;
        pdata = d;
        pis_b = is_b;
      end
      if (!is_b) begin
        last_a = d[11:0];
        next_b = !ign && (lat <= TO);
      end else begin
        next_b = 0;
        if (!ign && lat <= TO) exp_q.push_back({last_a, d[11:0]});
      end
    end
  endtask

  task automatic do_reset(input bit en_rel);
    rst_n = 1'b0;
    en = 1'b0;
    reset_model();
    repeat (3) step();
    en = en_rel;
    rst_n = 1'b1;
    r0 = cyc;
  endtask

  task automatic wait_rd(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!drp_rd_en && k < 60);
  endtask

  task automatic one_txn();
    int k;
    en = 1'b1;
    wait_rd(k);
    chk("txn_start", drp_rd_en, 1);
    en = 1'b0;
    repeat (90) step();
  endtask

  initial begin
    int k, v0, e_last;

    // Reset state
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_rd_en", drp_rd_en, 0);
    chk("rst_addr", drp_addr, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_overrun", overrun_err, 0);
    chk("rst_err_count", err_count, 0);

    // Periodic sampling with random data and short random latencies
    lat_a = $urandom_range(1, 5);
    lat_b = $urandom_range(1, 5);
    do_reset(1'b1);
    vcyc.delete();
    v0 = nvalid;
    repeat (104) step();
    en = 1'b0;
    repeat (40) step();
    chk("p1_valid_count", nvalid - v0, 6);
    if (vcyc.size() > 0) chk("p1_first_valid", vcyc[0] - r0, SP + 2 + lat_a + lat_b);
    for (int i = 1; i < vcyc.size(); i++) chk("p1_spacing", vcyc[i] - vcyc[i-1], SP);
    chk("p1_queue_empty", exp_q.size(), 0);
    chk("p1_err_count", err_count, 0);
    chk("p1_flags", {timeout_err, overrun_err}, 0);

    // Fixed data: upper bits above the ADC width are dropped
    do_reset(1'b0);
    lat_a = 1; lat_b = 1;
    fixed = 1; fix_a = 16'h0ABC; fix_b = 16'hF5A5;
    v0 = nvalid;
    one_txn();
    chk("p2_valid_count", nvalid - v0, 1);
    chk("p2_sample_a", sample_a, 12'hABC);
    chk("p2_sample_b", sample_b, 12'h5A5);

    // Channel B never answers: timeout after TIMEOUT cycles in WAIT_B
    ign_b = 1;
    v0 = nvalid;
    en = 1'b1;
    wait_rd(k);
    chk("p3_a_req", drp_addr, ADDR_A);
    en = 1'b0;
    wait_rd(k);
    chk("p3_b_req", drp_addr, ADDR_B);
    k = 0;
    do begin
      step();
      k++;
    end while (!timeout_err && k < 100);
    chk("p3_timeout_latency", k, TO + 1);
    repeat (10) step();
    chk("p3_no_valid", nvalid - v0, 0);
    chk("p3_err_count", err_count, 1);
    chk("p3_overrun", overrun_err, 0);
    chk("p3_sample_a_kept", sample_a, 12'hABC);
    chk("p3_sample_b_kept", sample_b, 12'h5A5);
    ign_b = 0;

    // Response in the final allowed cycle is a success
    fixed = 0;
    lat_b = TO;
    v0 = nvalid;
    one_txn();
    chk("p3b_valid_count", nvalid - v0, 1);
    chk("p3b_err_count", err_count, 1);
    chk("p3b_timeout_sticky", timeout_err, 1);

    // One cycle too late: timeout, and the late strobe is ignored
    lat_b = TO + 1;
    v0 = nvalid;
    one_txn();
    chk("p3c_no_valid", nvalid - v0, 0);
    chk("p3c_err_count", err_count, 2);

    // Spurious strobes while idle change nothing
    spur = 5;
    repeat (20) step();
    chk("p3d_no_valid", nvalid - v0, 0);
    chk("p3d_err_count", err_count, 2);
    lat_b = 2;
    one_txn();
    chk("p3d_after_valid", nvalid - v0, 1);

    // Overrun: long latency makes each pair span past the next tick
    lat_a = 7; lat_b = 7;
    do_reset(1'b1);
    vcyc.delete();
    v0 = nvalid;
    repeat (120) step();
    en = 1'b0;
    repeat (60) step();
    chk("p4_valid_count", nvalid - v0, 4);
    for (int i = 1; i < vcyc.size(); i++) chk("p4_spacing", vcyc[i] - vcyc[i-1], 2 * SP);
    chk("p4_err_count", err_count, 3);
    chk("p4_overrun", overrun_err, 1);
    chk("p4_timeout", timeout_err, 0);

    // Asynchronous reset in the middle of a transaction
    lat_a = 1; lat_b = 1;
    do_reset(1'b1);
    repeat (40) step();
    wait_rd(k);
    chk("p5_in_req", drp_rd_en, 1);
    rst_n = 1'b0;
    #1;
    chk("p5_async_rd_en", drp_rd_en, 0);
    chk("p5_async_addr", drp_addr, 0);
    chk("p5_async_a", sample_a, 0);
    chk("p5_async_b", sample_b, 0);
    chk("p5_async_err", err_count, 0);
    reset_model();
    repeat (3) step();
    rst_n = 1'b1;
    r0 = cyc;
    k = 0;
    do begin
      step();
      k++;
    end while (!sample_valid && k < 100);
    chk("p5_first_valid", k, SP + 4);
    en = 1'b0;
    repeat (20) step();

    // Tick coincides with a timeout (+2), then saturation
    lat_a = 14; ign_b = 1;
    do_reset(1'b1);
    k = 0;
    e_last = 0;
    while (!timeout_err && k < 200) begin
      e_last = err_count;
      step();
      k++;
    end
    chk("p6_err_before", e_last, 2);
    chk("p6_err_double", err_count, 4);
    chk("p6_overrun", overrun_err, 1);
    k = 0;
    while (err_count != 8'hFF && k < 8000) begin
      step();
      k++;
    end
    chk("p6_saturated", err_count, 8'hFF);
    repeat (300) step();
    chk("p6_still_saturated", err_count, 8'hFF);
    en = 1'b0;
    ign_b = 0;
    repeat (60) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
